// File: rtl/hazard_ctrl_d_if.sv
// Decode-side hazard interface: D-stage operand/destination info in, stall and
// forwarding select codes out. The decode logic holds the master modport.
interface hazard_ctrl_d_if;
    logic [4:0] rs_d;
    logic [4:0] rt_d;
    logic [1:0] tuse_rs;
    logic [1:0] tuse_rt;
    logic [4:0] dst_d;
    logic [1:0] kind_d;
    logic       md_start_d;
    logic       md_div_d;
    logic       md_use_d;
    logic       flush;
    logic       stall;
    logic [2:0] forward_src_rs;
    logic [2:0] forward_src_rt;
    logic       md_busy;

    modport master (
        output rs_d, rt_d, tuse_rs, tuse_rt, dst_d, kind_d,
        output md_start_d, md_div_d, md_use_d, flush,
        input  stall, forward_src_rs, forward_src_rt, md_busy
    );

    modport slave (
        input  rs_d, rt_d, tuse_rs, tuse_rt, dst_d, kind_d,
        input  md_start_d, md_div_d, md_use_d, flush,
        output stall, forward_src_rs, forward_src_rt, md_busy
    );
endinterface

// File: rtl/hazard_ctrl_d.sv
// D-stage hazard controller: shadow E/M/W destination record, forwarding selects
// and stall; the HI/LO busy timer exists only when HAZARD_MD_UNIT_EN is defined.
module hazard_ctrl_d #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic            clk,
    input  logic            reset_n,
    hazard_ctrl_d_if.slave  hz
);
    typedef struct packed {
        logic [4:0] dst;
        logic [1:0] kind;
    } ent_t;

    localparam logic [1:0] K_LINK = 2'd1;
    localparam logic [1:0] K_ALU  = 2'd2;
    localparam logic [1:0] K_LOAD = 2'd3;
    localparam ent_t       BUBBLE = '0;

    ent_t e_q, e_d, m_q, m_d, w_q, w_d;
    logic stall_rs, stall_rt, stall_md, stall;
    logic [2:0] src_rs, src_rt;
    logic md_busy;

    // Returns {stall, select}; the youngest matching entry decides.
    function automatic logic [3:0] resolve(input logic [4:0] r, input logic [1:0] tuse,
                                           input ent_t e, input ent_t m, input ent_t w);
        logic [1:0] tnew;
        logic [2:0] code;
        tnew = 2'd0;
        code = 3'd0;
        if (tuse != 2'd3 && r != 5'd0) begin
            if (e.dst == r) begin
                tnew = (e.kind == K_LOAD) ? 2'd2 : (e.kind == K_ALU) ? 2'd1 : 2'd0;
                code = (e.kind == K_LINK) ? 3'd1 : 3'd0;
            end else if (m.dst == r) begin
                tnew = (m.kind == K_LOAD) ? 2'd1 : 2'd0;
                code = (m.kind == K_LINK) ? 3'd3 : (m.kind == K_ALU) ? 3'd2 : 3'd0;
            end else if (w.dst == r) begin
                code = 3'd4;
            end
        end
        if (tnew > tuse) return {1'b1, 3'd0};
        return {1'b0, code};
    endfunction

    always_comb begin
        {stall_rs, src_rs} = resolve(hz.rs_d, hz.tuse_rs, e_q, m_q, w_q);
        {stall_rt, src_rt} = resolve(hz.rt_d, hz.tuse_rt, e_q, m_q, w_q);
        stall = stall_rs | stall_rt | stall_md;
    end

    always_comb begin
        e_d = BUBBLE;
        m_d = e_q;
        w_d = m_q;
        if (hz.flush) begin
            m_d = BUBBLE;
            w_d = BUBBLE;
        end else if (!stall) begin
            e_d = '{dst: hz.dst_d, kind: hz.kind_d};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_q <= BUBBLE;
            m_q <= BUBBLE;
            w_q <= BUBBLE;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
            w_q <= w_d;
        end
    end

`ifdef HAZARD_MD_UNIT_EN
    localparam int MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW     = $clog2(MD_MAX + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // A flush does not cancel a unit already started; it only blocks a new start.
    always_comb begin
        cnt_d = cnt_q;
        if (hz.md_start_d && !stall && !hz.flush) begin
            cnt_d = hz.md_div_d ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign md_busy  = (cnt_q != '0);
    assign stall_md = hz.md_use_d & md_busy;
`else
    localparam int md_params_unused = MULT_CYCLES + DIV_CYCLES;
    logic md_inputs_unused;
    assign md_inputs_unused = hz.md_start_d ^ hz.md_div_d ^ hz.md_use_d;
    assign md_busy  = 1'b0;
    assign stall_md = 1'b0;
`endif

    assign hz.stall          = stall;
    assign hz.forward_src_rs = src_rs;
    assign hz.forward_src_rt = src_rt;
    assign hz.md_busy        = md_busy;
endmodule

// File: tb/tb_hazard_ctrl_d.sv
// Directed bench for hazard_ctrl_d: a driver issues one D-stage vector per cycle
// and queues the hand-computed response; a negedge monitor pops and compares.
module tb_hazard_ctrl_d;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    hazard_ctrl_d_if hz ();

    hazard_ctrl_d #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .hz      (hz)
    );

`ifdef HAZARD_MD_UNIT_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    localparam logic [1:0] K_NONE = 2'd0;
    localparam logic [1:0] K_LINK = 2'd1;
    localparam logic [1:0] K_ALU  = 2'd2;
    localparam logic [1:0] K_LOAD = 2'd3;

    // expected response packed as {stall, forward_src_rs, forward_src_rt, md_busy}
    logic [7:0] exp_q[$];
    int         id_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         n_issued = 0;
    logic       rst_drv = 1'b0;

    function automatic logic [7:0] ex(input logic st, input logic [2:0] a,
                                      input logic [2:0] b, input logic busy);
        return {st, a, b, busy};
    endfunction

    task automatic step(input logic [4:0] rs, input logic [4:0] rt,
                        input logic [1:0] tr, input logic [1:0] tt,
                        input logic [4:0] dst, input logic [1:0] kind,
                        input logic [2:0] md, input logic fl, input logic [7:0] e);
        @(posedge clk);
        #1;
        reset_n    = rst_drv;
        hz.rs_d    = rs;
        hz.rt_d    = rt;
        hz.tuse_rs = tr;
        hz.tuse_rt = tt;
        hz.dst_d   = dst;
        hz.kind_d  = kind;
        {hz.md_start_d, hz.md_div_d, hz.md_use_d} = md;
        hz.flush   = fl;
        exp_q.push_back(e);
        id_q.push_back(n_issued);
        n_issued++;
    endtask

    task automatic nop(input logic [7:0] e);
        step(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, K_NONE, 3'b000, 1'b0, e);
    endtask

    // monitor / scoreboard
    initial begin
        forever begin
            logic [7:0] e, a;
            int id;
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                id = id_q.pop_front();
                a  = {hz.stall, hz.forward_src_rs, hz.forward_src_rt, hz.md_busy};
                n_vec++;
                if (a !== e) begin
                    n_err++;
                    $display("FAIL vec%0d stall/rs/rt/busy got %b/%0d/%0d/%b want %b/%0d/%0d/%b",
                             id, a[7], a[6:4], a[3:1], a[0], e[7], e[6:4], e[3:1], e[0]);
                end
            end
        end
    end

    initial begin
        reset_n       = 1'b0;
        hz.rs_d       = '0;
        hz.rt_d       = '0;
        hz.tuse_rs    = 2'd3;
        hz.tuse_rt    = 2'd3;
        hz.dst_d      = '0;
        hz.kind_d     = K_NONE;
        hz.md_start_d = 1'b0;
        hz.md_div_d   = 1'b0;
        hz.md_use_d   = 1'b0;
        hz.flush      = 1'b0;
        repeat (2) @(posedge clk);
        nop(ex(0, 0, 0, 0));
        rst_drv = 1'b1;

        // ALU chain, consumer held in D: E no-forward, then M (2), then W (4)
        step(5'd1, 5'd2, 2'd1, 2'd1, 5'd3, K_ALU, 3'b000, 1'b0, ex(0, 0, 0, 0));
        step(5'd3, 5'd0, 2'd1, 2'd3, 5'd4, K_ALU, 3'b000, 1'b0, ex(0, 0, 0, 0));
        step(5'd3, 5'd0, 2'd1, 2'd3, 5'd4, K_ALU, 3'b000, 1'b0, ex(0, 2, 0, 0));
        step(5'd3, 5'd0, 2'd1, 2'd3, 5'd4, K_ALU, 3'b000, 1'b0, ex(0, 4, 0, 0));
        repeat (3) nop(ex(0, 0, 0, 0));

        // load-use with tuse 0: two stalls then W forward
        step(5'd29, 5'd0, 2'd1, 2'd3, 5'd5, K_LOAD, 3'b000, 1'b0, ex(0, 0, 0, 0));
        step(5'd5, 5'd6, 2'd0, 2'd0, 5'd0, K_NONE, 3'b000, 1'b0, ex(1, 0, 0, 0));
        step(5'd5, 5'd6, 2'd0, 2'd0, 5'd0, K_NONE, 3'b000, 1'b0, ex(1, 0, 0, 0));
        step(5'd5, 5'd6, 2'd0, 2'd0, 5'd0, K_NONE, 3'b000, 1'b0, ex(0, 4, 0, 0));
        repeat (2) nop(ex(0, 0, 0, 0));

        // same register written twice: youngest producer wins
        step(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, K_ALU, 3'b000, 1'b0, ex(0, 0, 0, 0));
        step(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, K_LINK, 3'b000, 1'b0, ex(0, 0, 0, 0));
        step(5'd8, 5'd8, 2'd0, 2'd3, 5'd0, K_NONE, 3'b000, 1'b0, ex(0, 1, 0, 0));
        step(5'd0, 5'd8, 2'd3, 2'd0, 5'd0, K_NONE, 3'b000, 1'b0, ex(0, 0, 3, 0));
        step(5'd8, 5'd8, 2'd2, 2'd1, 5'd0, K_NONE, 3'b000, 1'b0, ex(0, 4, 4, 0));
        repeat (2) nop(ex(0, 0, 0, 0));

        // ALU result with tuse 0 on rt: one stall then M forward
        step(5'd0, 5'd0, 2'd3, 2'd3, 5'd9, K_ALU, 3'b000, 1'b0, ex(0, 0, 0, 0));
        step(5'd0, 5'd9, 2'd3, 2'd0, 5'd0, K_NONE, 3'b000, 1'b0, ex(1, 0, 0, 0));
        step(5'd0, 5'd9, 2'd3, 2'd0, 5'd0, K_NONE, 3'b000, 1'b0, ex(0, 0, 2, 0));
        repeat (3) nop(ex(0, 0, 0, 0));

        // flush while a load-use stall is pending: everything becomes a bubble
        step(5'd0, 5'd0, 2'd3, 2'd3, 5'd7, K_LOAD, 3'b000, 1'b0, ex(0, 0, 0, 0));
        step(5'd7, 5'd0, 2'd0, 2'd3, 5'd0, K_NONE, 3'b000, 1'b1, ex(1, 0, 0, 0));
        step(5'd7, 5'd0, 2'd0, 2'd3, 5'd0, K_NONE, 3'b000, 1'b0, ex(0, 0, 0, 0));
        nop(ex(0, 0, 0, 0));

        // div then mflo: busy and stalled for 10 cycles when the unit exists
        step(5'd10, 5'd11, 2'd1, 2'd1, 5'd0, K_NONE, 3'b111, 1'b0, ex(0, 0, 0, 0));
        for (int i = 0; i < 11; i++)
            step(5'd0, 5'd0, 2'd3, 2'd3, 5'd12, K_ALU, 3'b001, 1'b0,
                 ex(MD_EN && (i < 10), 0, 0, MD_EN && (i < 10)));

        // mult then mfhi: 5 stall cycles
        step(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, K_NONE, 3'b101, 1'b0, ex(0, 0, 0, 0));
        for (int i = 0; i < 6; i++)
            step(5'd0, 5'd0, 2'd3, 2'd3, 5'd12, K_ALU, 3'b001, 1'b0,
                 ex(MD_EN && (i < 5), 0, 0, MD_EN && (i < 5)));

        // flush after mult does not cancel the running unit
        step(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, K_NONE, 3'b101, 1'b0, ex(0, 0, 0, 0));
        step(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, K_NONE, 3'b000, 1'b1, ex(0, 0, 0, MD_EN));
        for (int i = 0; i < 5; i++)
            step(5'd0, 5'd0, 2'd3, 2'd3, 5'd12, K_ALU, 3'b001, 1'b0,
                 ex(MD_EN && (i < 4), 0, 0, MD_EN && (i < 4)));

        // reset mid-stream with a load in M and a div running
        step(5'd0, 5'd0, 2'd3, 2'd3, 5'd13, K_LOAD, 3'b000, 1'b0, ex(0, 0, 0, 0));
        step(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, K_NONE, 3'b111, 1'b0, ex(0, 0, 0, 0));
        rst_drv = 1'b0;
        step(5'd13, 5'd0, 2'd0, 2'd3, 5'd0, K_NONE, 3'b001, 1'b0, ex(0, 0, 0, 0));
        rst_drv = 1'b1;
        step(5'd13, 5'd0, 2'd0, 2'd3, 5'd0, K_NONE, 3'b001, 1'b0, ex(0, 0, 0, 0));
        nop(ex(0, 0, 0, 0));

        for (int i = 0; i < 10; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain pending=%0d want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
